// File: rtl/controle_registradores_pkg.sv
// ctrl_pkg: shared types and constants for the controle_registradores microsequencer.
// Holds opcode / ALU-function / B-bus / C-bus encodings, the FSM state enum,
// the latched-instruction struct and the registered control payload struct.
package ctrl_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned SRC_W   = 4;
    localparam int unsigned DST_W   = 4;
    localparam int unsigned INSTR_W = OP_W + SRC_W + DST_W;
    localparam int unsigned CBUS_W  = 10;
    localparam int unsigned ALU_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_MOV   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_INC   = 3'd4,
        OP_LOAD  = 3'd5,
        OP_STORE = 3'd6,
        OP_ILL   = 3'd7
    } opcode_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_PASS_B = 2'd0,
        ALU_ADD    = 2'd1,
        ALU_SUB    = 2'd2,
        ALU_INC    = 2'd3
    } alu_op_e;

    // B-bus source codes
    localparam logic [SRC_W-1:0] BSRC_MDR = 4'd1;
    localparam logic [SRC_W-1:0] BSRC_SP  = 4'd4;
    localparam logic [SRC_W-1:0] BSRC_LV  = 4'd5;
    localparam logic [SRC_W-1:0] BSRC_CPP = 4'd6;
    localparam logic [SRC_W-1:0] BSRC_TOS = 4'd7;
    localparam logic [SRC_W-1:0] BSRC_OPC = 4'd8;

    // C-bus write-enable bit indices
    localparam int unsigned CB_MAR = 0;
    localparam int unsigned CB_MDR = 1;
    localparam int unsigned CB_PC  = 2;
    localparam int unsigned CB_MBR = 3;
    localparam int unsigned CB_SP  = 4;
    localparam int unsigned CB_LV  = 5;
    localparam int unsigned CB_CPP = 6;
    localparam int unsigned CB_TOS = 7;
    localparam int unsigned CB_OPC = 8;
    localparam int unsigned CB_H   = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_WB       = 3'd4
    } state_e;

    // Field order matches instr_in: [10:8] opcode, [7:4] src, [3:0] dst
    typedef struct packed {
        opcode_e          op;
        logic [SRC_W-1:0] src;
        logic [DST_W-1:0] dst;
    } instr_t;

    typedef struct packed {
        logic [SRC_W-1:0]  bbus;
        logic [CBUS_W-1:0] cbus;
        alu_op_e           alu;
        logic              mem_rd;
        logic              mem_wr;
    } ctrl_out_t;

    function automatic logic src_legal(input logic [SRC_W-1:0] src);
        return src inside {BSRC_MDR, BSRC_SP, BSRC_LV, BSRC_CPP, BSRC_TOS, BSRC_OPC};
    endfunction

    // NOP uses neither field, so only its opcode matters
    function automatic logic instr_legal(input instr_t i);
        if (i.op == OP_ILL) return 1'b0;
        if (i.op == OP_NOP) return 1'b1;
        return src_legal(i.src) && (i.dst <= DST_W'(CB_H));
    endfunction

    // Indices above CB_H shift out to zero, so an out-of-range index never enables a register
    function automatic logic [CBUS_W-1:0] cbus_onehot(input logic [DST_W-1:0] idx);
        return CBUS_W'(1) << idx;
    endfunction

    function automatic alu_op_e alu_of(input opcode_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_INC:  return ALU_INC;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/controle_registradores_if.sv
// controle_registradores_if: instruction handshake plus datapath control bundle.
//   master: instruction source / memory side (drives instr_valid, instr_in, mem_ready)
//   slave : the microsequencer (drives instr_ready and all control outputs)
interface controle_registradores_if;
    import ctrl_pkg::*;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr_in;
    logic               instr_ready;
    logic               mem_ready;
    logic [SRC_W-1:0]   bbus_sig;
    logic [CBUS_W-1:0]  cbus_sig;
    logic [ALU_W-1:0]   alu_op;
    logic               mem_rd;
    logic               mem_wr;
    logic               done;
    logic               err;

    modport master (
        output instr_valid, instr_in, mem_ready,
        input  instr_ready, bbus_sig, cbus_sig, alu_op, mem_rd, mem_wr, done, err
    );

    modport slave (
        input  instr_valid, instr_in, mem_ready,
        output instr_ready, bbus_sig, cbus_sig, alu_op, mem_rd, mem_wr, done, err
    );

endinterface

// File: rtl/controle_registradores_timeout.sv
// ctrl_timeout: MEM_WAIT cycle counter.
//   clear   : restart counting (asserted on entry to MEM_WAIT)
//   tick    : one wait cycle elapsed
//   expired : registered; high during the last allowed wait cycle
// Only instantiated when CTRL_TIMEOUT_EN is defined.
module ctrl_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST_CNT = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    // expired flags the cycle whose count equals the final index, one cycle ahead of the count itself
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = expired_q;
        if (clear) begin
            cnt_d     = '0;
            expired_d = (LAST_CNT == 0);
        end else if (tick && !expired_q) begin
            cnt_d     = cnt_q + CNT_W'(1);
            expired_d = ((cnt_q + CNT_W'(1)) == CNT_W'(LAST_CNT));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/controle_registradores.sv
// controle_registradores: microsequencer for register bank / ALU / RAM control.
// Accepts one 11-bit instruction over valid/ready, expands it into 1-4 control
// cycles (EXEC, MEM_WAIT, CAPTURE, WB) and pulses done (legal) or err (illegal
// or memory timeout) on return to IDLE.
//   clock, reset_n : system clock, async active-low reset
//   bus (slave)    : instr_valid/instr_in/instr_ready, mem_ready,
//                    bbus_sig, cbus_sig, alu_op, mem_rd, mem_wr, done, err
// Optional feature: define CTRL_TIMEOUT_EN to abort MEM_WAIT after
// TIMEOUT_CYCLES cycles without mem_ready.
module controle_registradores
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    controle_registradores_if.slave  bus
);

    state_e    state_q, state_d;
    instr_t    instr_q, instr_d;
    ctrl_out_t out_q, out_d;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic      idle_q, idle_d;
    logic      timeout_expired;

`ifdef CTRL_TIMEOUT_EN
    logic timeout_clear;
    logic timeout_tick;

    assign timeout_clear = (state_d == ST_MEM_WAIT) && (state_q != ST_MEM_WAIT);
    assign timeout_tick  = (state_q == ST_MEM_WAIT);

    ctrl_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timeout_clear),
        .tick    (timeout_tick),
        .expired (timeout_expired)
    );
`else
    logic [31:0] timeout_cfg_unused;

    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign timeout_expired    = 1'b0;
`endif

    // Next state, then Moore outputs for the state being entered so they register alongside it
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        out_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = instr_t'(bus.instr_in);
                    if (instr_legal(instr_d)) state_d = ST_EXEC;
                    else                      err_d   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (instr_q.op == OP_LOAD || instr_q.op == OP_STORE) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // mem_ready wins over a simultaneous timeout
                if (bus.mem_ready) begin
                    if (instr_q.op == OP_LOAD) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (timeout_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_WB;
            ST_WB: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_EXEC: begin
                case (instr_d.op)
                    OP_MOV, OP_ADD, OP_SUB, OP_INC: begin
                        out_d.bbus = instr_d.src;
                        out_d.alu  = alu_of(instr_d.op);
                        out_d.cbus = cbus_onehot(instr_d.dst);
                    end
                    OP_LOAD, OP_STORE: begin
                        // address phase: src -> MAR
                        out_d.bbus = instr_d.src;
                        out_d.alu  = ALU_PASS_B;
                        out_d.cbus = cbus_onehot(DST_W'(CB_MAR));
                    end
                    default: out_d = '0;
                endcase
            end
            ST_MEM_WAIT: begin
                out_d.mem_rd = (instr_d.op == OP_LOAD);
                out_d.mem_wr = (instr_d.op == OP_STORE);
            end
            ST_CAPTURE: out_d.cbus = cbus_onehot(DST_W'(CB_MDR));
            ST_WB: begin
                out_d.bbus = BSRC_MDR;
                out_d.alu  = ALU_PASS_B;
                out_d.cbus = cbus_onehot(instr_d.dst);
            end
            default: out_d = '0;
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
        end
    end

    // ready is held low while reset is asserted and returns high as soon as it is released
    assign bus.instr_ready = reset_n & idle_q;
    assign bus.bbus_sig    = out_q.bbus;
    assign bus.cbus_sig    = out_q.cbus;
    assign bus.alu_op      = out_q.alu;
    assign bus.mem_rd      = out_q.mem_rd;
    assign bus.mem_wr      = out_q.mem_wr;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_controle_registradores.sv
// Testbench for controle_registradores: directed table, random instructions
// against a per-instruction expected-cycle model, and hand-written reset /
// memory-wait sequences. Honours CTRL_TIMEOUT_EN for the timeout behaviour.
module tb_controle_registradores;

    localparam int TO = 4;
`ifdef CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    controle_registradores_if bus();

    controle_registradores #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] bbus;
        logic [9:0] cbus;
        logic [1:0] alu;
        logic       rd, wr, done, err, ready;
        int         widx;   // 1-based memory wait cycle number, 0 otherwise
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        int          wait_n;
        logic [15:0] first;  // {bbus, cbus, alu} in the cycle after acceptance
        int          len;    // cycle index (1-based) carrying done or err
        logic        is_err;
    } vec_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [20:0] obs();
        return {bus.bbus_sig, bus.cbus_sig, bus.alu_op, bus.mem_rd, bus.mem_wr,
                bus.done, bus.err, bus.instr_ready};
    endfunction

    function automatic logic [20:0] pack_exp(input exp_t e);
        return {e.bbus, e.cbus, e.alu, e.rd, e.wr, e.done, e.err, e.ready};
    endfunction

    function automatic exp_t rec(input int bbus, input int cbus, input int alu,
                                 input bit rd, input bit wr, input bit dn,
                                 input bit er, input bit rdy, input int widx);
        exp_t e;
        e.bbus = 4'(bbus);  e.cbus = 10'(cbus); e.alu = 2'(alu);
        e.rd = rd; e.wr = wr; e.done = dn; e.err = er; e.ready = rdy; e.widx = widx;
        return e;
    endfunction

    // Expected per-cycle outputs after acceptance, from the instruction semantics
    task automatic build(input int op, input int src, input int dst, input int wait_n);
        bit legal;
        bit ld;
        bit timed_out;
        int nw;
        int alu;
        expq.delete();
        legal = (op != 7) && ((op == 0) ||
                ((src inside {1, 4, 5, 6, 7, 8}) && dst <= 9));
        if (!legal) begin
            expq.push_back(rec(0, 0, 0, 0, 0, 0, 1, 1, 0));
            return;
        end
        if (op == 0) begin
            expq.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0, 0));
            expq.push_back(rec(0, 0, 0, 0, 0, 1, 0, 1, 0));
        end else if (op <= 4) begin
            alu = op - 1;   // MOV->PASS_B, ADD, SUB, INC
            expq.push_back(rec(src, 1 << dst, alu, 0, 0, 0, 0, 0, 0));
            expq.push_back(rec(0, 0, 0, 0, 0, 1, 0, 1, 0));
        end else begin
            ld = (op == 5);
            timed_out = TO_EN && (wait_n == 0 || wait_n > TO);
            nw = timed_out ? TO : wait_n;
            expq.push_back(rec(src, 1, 0, 0, 0, 0, 0, 0, 0));
            for (int k = 1; k <= nw; k++)
                expq.push_back(rec(0, 0, 0, ld, !ld, 0, 0, 0, k));
            if (timed_out) begin
                expq.push_back(rec(0, 0, 0, 0, 0, 0, 1, 1, 0));
            end else begin
                if (ld) begin
                    expq.push_back(rec(0, 2, 0, 0, 0, 0, 0, 0, 0));
                    expq.push_back(rec(1, 1 << dst, 0, 0, 0, 0, 0, 0, 0));
                end
                expq.push_back(rec(0, 0, 0, 0, 0, 1, 0, 1, 0));
            end
        end
    endtask

    // Called #1 after an edge while the DUT is idle; returns #1 after the done/err edge
    task automatic run_instr(input int op, input int src, input int dst, input int wait_n,
                             output logic [20:0] first, output int len, output logic is_err);
        logic [20:0] o;
        build(op, src, dst, wait_n);
        bus.instr_valid = 1'b1;
        bus.instr_in    = {3'(op), 4'(src), 4'(dst)};
        len = 0; is_err = 1'b0; first = '0;
        foreach (expq[i]) begin
            @(posedge clock); #1;
            bus.instr_valid = 1'b0;
            bus.instr_in    = 11'($urandom);
            o = obs();
            if (i == 0) first = o;
            if ((bus.done || bus.err) && len == 0) begin
                len = i + 1;
                is_err = bus.err;
            end
            check($sformatf("seq op%0d src%0d dst%0d w%0d cyc%0d", op, src, dst, wait_n, i),
                  32'(o), 32'(pack_exp(expq[i])));
            if (expq[i].widx != 0) bus.mem_ready = (expq[i].widx == wait_n);
            else                   bus.mem_ready = 1'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        logic [20:0] first;
        int          len;
        logic        is_err;
        int          op, src, dst, wn;
        int          legal_src[6] = '{1, 4, 5, 6, 7, 8};

        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        bus.mem_ready   = 1'b0;

        // op, src, dst, wait, {bbus,cbus,alu}, len, err
        tbl.push_back('{3'd1, 4'd4, 4'd9, 1, {4'd4, 10'h200, 2'd0}, 2, 1'b0});
        tbl.push_back('{3'd2, 4'd7, 4'd7, 1, {4'd7, 10'h080, 2'd1}, 2, 1'b0});
        tbl.push_back('{3'd3, 4'd5, 4'd4, 1, {4'd5, 10'h010, 2'd2}, 2, 1'b0});
        tbl.push_back('{3'd4, 4'd8, 4'd0, 1, {4'd8, 10'h001, 2'd3}, 2, 1'b0});
        tbl.push_back('{3'd0, 4'd0, 4'd0, 1, {4'd0, 10'h000, 2'd0}, 2, 1'b0});
        tbl.push_back('{3'd1, 4'd1, 4'd9, 1, {4'd1, 10'h200, 2'd0}, 2, 1'b0});
        tbl.push_back('{3'd5, 4'd5, 4'd8, 3, {4'd5, 10'h001, 2'd0}, 7, 1'b0});
        tbl.push_back('{3'd5, 4'd1, 4'd3, 1, {4'd1, 10'h001, 2'd0}, 5, 1'b0});
        tbl.push_back('{3'd6, 4'd6, 4'd2, 1, {4'd6, 10'h001, 2'd0}, 3, 1'b0});
        tbl.push_back('{3'd6, 4'd4, 4'd0, 4, {4'd4, 10'h001, 2'd0}, 6, 1'b0});
        tbl.push_back('{3'd7, 4'd4, 4'd0, 1, {4'd0, 10'h000, 2'd0}, 1, 1'b1});
        tbl.push_back('{3'd1, 4'd2, 4'd0, 1, {4'd0, 10'h000, 2'd0}, 1, 1'b1});
        tbl.push_back('{3'd1, 4'd4, 4'd12, 1, {4'd0, 10'h000, 2'd0}, 1, 1'b1});
        tbl.push_back('{3'd2, 4'd0, 4'd1, 1, {4'd0, 10'h000, 2'd0}, 1, 1'b1});
        tbl.push_back('{3'd4, 4'd8, 4'd10, 1, {4'd0, 10'h000, 2'd0}, 1, 1'b1});

        // reset state
        #12;
        check("reset_outputs", 32'(obs()), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.instr_ready), 32'h1);
        @(posedge clock); #1;
        check("idle_outputs", 32'(obs()), 32'h1);

        // directed table, issued back-to-back
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].wait_n, first, len, is_err);
            check($sformatf("tbl%0d_exec", i), 32'(first[20:5]), 32'(tbl[i].first));
            check($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].len));
            check($sformatf("tbl%0d_err", i), 32'(is_err), 32'(tbl[i].is_err));
        end

        // random instruction stream with occasional idle gaps
        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 7);
            src = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15)
                                              : legal_src[$urandom_range(0, 5)];
            dst = $urandom_range(0, 11);
            if (op == 0) begin
                src = legal_src[$urandom_range(0, 5)];
                dst = $urandom_range(0, 9);
            end
            wn = $urandom_range(1, 6);
            if (TO_EN && $urandom_range(0, 7) == 0) wn = 0;
            run_instr(op, src, dst, wn, first, len, is_err);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clock); #1;
                check("idle_gap", 32'(obs()), 32'h1);
            end
        end

        // STORE with mem_ready never asserted
        bus.mem_ready = 1'b0;
        if (TO_EN) begin
            run_instr(6, 4, 0, 0, first, len, is_err);
            check("store_timeout_len", 32'(len), 32'(TO + 2));
            check("store_timeout_err", 32'(is_err), 32'h1);
        end else begin
            bus.instr_valid = 1'b1;
            bus.instr_in    = {3'd6, 4'd4, 4'd0};
            @(posedge clock); #1;
            bus.instr_valid = 1'b0;
            check("store_hang_exec", 32'(obs()), 32'(pack_exp(rec(4, 1, 0, 0, 0, 0, 0, 0, 0))));
            for (int c = 0; c < 3 * TO + 4; c++) begin
                @(posedge clock); #1;
                check($sformatf("store_hang_wait%0d", c), 32'(obs()),
                      32'(pack_exp(rec(0, 0, 0, 0, 1, 0, 0, 0, 0))));
            end
            #2 reset_n = 1'b0;
            #1 check("store_hang_reset", 32'(obs()), 32'h0);
            @(negedge clock);
            reset_n = 1'b1;
            @(posedge clock); #1;
        end

        // reset pulled low mid MEM_WAIT of a LOAD
        bus.instr_valid = 1'b1;
        bus.instr_in    = {3'd5, 4'd5, 4'd8};
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        check("ld_rst_exec", 32'(obs()), 32'(pack_exp(rec(5, 1, 0, 0, 0, 0, 0, 0, 0))));
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            check($sformatf("ld_rst_wait%0d", c), 32'(obs()),
                  32'(pack_exp(rec(0, 0, 0, 1, 0, 0, 0, 0, 0))));
        end
        #2 reset_n = 1'b0;
        #1 check("ld_rst_async_zero", 32'(obs()), 32'h0);
        bus.mem_ready = 1'b1;
        @(posedge clock); #1;
        check("ld_rst_held", 32'(obs()), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("ld_rst_release_ready", 32'(obs()), 32'h1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            bus.mem_ready = 1'($urandom);
            check($sformatf("ld_rst_quiet%0d", c), 32'(obs()), 32'h1);
        end
        run_instr(1, 4, 9, 1, first, len, is_err);
        check("post_reset_mov_len", 32'(len), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_registradores.md
# controle_registradores

Microsequencer that drives the register bank's B-bus select, C-bus write enables, ALU function and memory strobes, one instruction at a time. It accepts a compact instruction over a valid/ready handshake and expands it into a fixed sequence of 1–4 control cycles. It then pulses `done`. It sits between the instruction source (testbench or future fetch unit) and the register bank / ALU / RAM datapath.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum `MEM_WAIT` cycles before abort; used only with the timeout feature.
- `clock`  in  1  single system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction present on `instr_in`.
- `instr_in`  in  11  [10:8] opcode, [7:4] src (B-bus code), [3:0] dst (C-bus bit index 0–9).
- `instr_ready`  out  1  high only in `IDLE`; reset value 1 after reset release, 0 while `reset_n` is low.
- `mem_ready`  in  1  memory completion strobe, sampled in `MEM_WAIT`.
- `bbus_sig`  out  4  B-bus source code; reset 0.
- `cbus_sig`  out  10  C-bus write enables: bit0 MAR, 1 MDR, 2 PC, 3 MBR, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9 H; reset 0.
- `alu_op`  out  2  0 PASS_B, 1 ADD (H+B), 2 SUB (H−B), 3 INC (B+1); reset 0.
- `mem_rd`, `mem_wr`  out  1  memory strobes; reset 0.
- `done`  out  1  one-cycle pulse on return to `IDLE` after a legal instruction; reset 0.
- `err`  out  1  one-cycle pulse on illegal instruction or timeout; reset 0.

## Operation
- Opcodes: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 INC, 5 LOAD, 6 STORE, 7 illegal.
- Legal src codes: 1 MDR, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC. Legal dst: 0–9.
- Acceptance: the instruction is accepted on a rising edge where `instr_valid` and `instr_ready` are both high. It is latched internally, so `instr_in` may change after that edge.
- Illegal instruction: opcode 7, an illegal src, or an illegal dst for any non-NOP opcode.
  - On acceptance the FSM goes to `IDLE` with `err`=1 for one cycle and `done`=0.
  - No `cbus_sig` bit is ever asserted for an illegal instruction.
- States: `IDLE`, `EXEC`, `MEM_WAIT`, `CAPTURE`, `WB`.
- NOP: `EXEC` with all control outputs 0, then `IDLE`.
- MOV, ADD, SUB, INC: one `EXEC` cycle, then `IDLE`.
  - `EXEC` drives `bbus_sig`=src, `alu_op` per opcode (MOV→PASS_B), and `cbus_sig`=one-hot(dst).
- LOAD, in sequence:
  - `EXEC`: `bbus_sig`=src, PASS_B, `cbus_sig`[0]=1.
  - `MEM_WAIT`: `mem_rd`=1 until `mem_ready` is sampled 1.
  - `CAPTURE`: `cbus_sig`[1]=1.
  - `WB`: `bbus_sig`=1, PASS_B, `cbus_sig`=one-hot(dst).
  - Then `IDLE`.
- STORE: `EXEC` as in LOAD, then `MEM_WAIT` with `mem_wr`=1 until `mem_ready`, then `IDLE`. dst is ignored.
- All control outputs are 0 in `IDLE`. At most one `cbus_sig` bit is high in any cycle.
- `mem_ready` outside `MEM_WAIT` is ignored.

## Timing
- All outputs are registered (Moore on state). The datapath latches on the edge that ends each control cycle.
- Accepted at edge T0: `EXEC` occupies cycle T0→T1.
- ALU/NOP instructions: `done`=1 and `instr_ready`=1 in cycle T1→T2, so back-to-back issue every 2 cycles.
- LOAD with `mem_ready` high in the first wait cycle: `done` in the 5th cycle after T0. Each extra wait cycle adds 1.
- STORE with zero wait: `done` in the 3rd cycle after T0.
- `reset_n` low at any time, including mid-`MEM_WAIT`:
  - Immediately forces `IDLE` and zeroes all outputs and the latched instruction.
  - No `done` or `err` follows.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - A counter clears on entry to `MEM_WAIT` and increments each wait cycle.
  - If `TIMEOUT_CYCLES` wait cycles elapse without `mem_ready`, the FSM drops the strobes, goes to `IDLE` and pulses `err` (not `done`).
  - For LOAD, `CAPTURE` and `WB` are skipped.
- `CTRL_TIMEOUT_EN` undefined: `MEM_WAIT` waits indefinitely and no counter logic exists.

## Structure
- Shared package `ctrl_pkg`, containing:
  - opcode constants;
  - `alu_op` constants;
  - B-bus source codes;
  - C-bus bit indices;
  - state enum typedef;
  - decoded-instruction struct.
- One sub-module: `ctrl_timeout`, the wait counter with `clear`/`tick`/`expired`. It is instantiated only under `CTRL_TIMEOUT_EN`.

## Test plan
- Reset, then MOV src=4 (SP) dst=9 (H) → `EXEC` shows `bbus_sig`=4, `alu_op`=0, `cbus_sig`=10'h200; `done` one cycle later; `instr_ready` back to 1.
- ADD src=7 dst=7, issued back-to-back with SUB src=5 dst=4 → accepts every 2 cycles; `cbus_sig` shows 10'h080 then 10'h010; `alu_op` shows 1 then 2.
- LOAD src=5 dst=8 with `mem_ready` delayed 3 cycles → `cbus_sig` 10'h001, then `mem_rd` for 3 cycles, then 10'h002, then `bbus_sig`=1 with 10'h100, then `done`.
- Illegal cases: opcode 7, src=2, and MOV dst=12 → each gives `err` pulse, no `done`, `cbus_sig` stays 0.
- STORE with `mem_ready` never asserted, `TIMEOUT_CYCLES`=4, macro on → `mem_wr` high for exactly 4 cycles, then `err`, then `IDLE`. With macro off → stays in `MEM_WAIT`.
- `reset_n` pulled low mid-`MEM_WAIT` of a LOAD → all outputs 0 asynchronously; after release, `instr_ready`=1 and no `done`.
